// File: rtl/led_blink_pwm.sv
// led_blink_pwm
//
// Programmable-period blink counter with per-channel LED drive. A main counter
// runs 0..period_r and raises tick on its terminal count. Each LED channel
// either shows a binary-divided toggle of that tick (blink mode) or a duty
// compare against a free-running PWM counter (PWM mode).
//
// Ports:
//   clk     board clock, all state updates on its rising edge
//   reset   synchronous active-high reset, priority over load and en
//   en      count enable; counters hold and tick is 0 while low
//   load    one-cycle strobe capturing period, mode and duty
//   period  terminal count, counter runs 0..period (period+1 states)
//   mode    per channel: 0 = blink, 1 = PWM
//   duty    per-channel duty, channel i uses [i*PWM_BITS +: PWM_BITS]
//   count   registered main counter value
//   tick    wrap indicator, en & (count >= period_r)
//   led     registered LED drive
module led_blink_pwm #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         load,
  input  logic [WIDTH-1:0]             period,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS*PWM_BITS-1:0] duty,
  output logic [WIDTH-1:0]             count,
  output logic                         tick,
  output logic [CHANNELS-1:0]          led
);

  logic [WIDTH-1:0]             count_r;
  logic [WIDTH-1:0]             period_r;
  logic [CHANNELS-1:0]          mode_r;
  logic [CHANNELS*PWM_BITS-1:0] duty_r;
  logic [CHANNELS-1:0]          tick_cnt;
  logic [CHANNELS-1:0]          blink_q;
  logic [CHANNELS-1:0]          blink_next;
  logic [PWM_BITS-1:0]          pwm_cnt;
  logic [CHANNELS-1:0]          led_r;
  logic [CHANNELS-1:0]          led_next;
  logic                         carry;

  // Using >= rather than == means a period shrunk below the current count
  // still wraps on the next enabled cycle instead of running to 2^WIDTH.
  assign tick  = en & (count_r >= period_r);
  assign count = count_r;
  assign led   = led_r;

  // Channel i toggles when tick fires with the low i bits of tick_cnt all
  // ones. The LED takes the post-toggle blink value so there is no extra
  // latency; PWM channels compare the current pwm_cnt, landing one cycle later.
  always_comb begin
    blink_next = blink_q;
    led_next   = '0;
    carry      = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      carry = tick;
      for (int j = 0; j < i; j++) begin
        carry = carry & tick_cnt[j];
      end
      if (carry) begin
        blink_next[i] = ~blink_q[i];
      end
      led_next[i] = mode_r[i] ? (pwm_cnt < duty_r[i*PWM_BITS +: PWM_BITS])
                              : blink_next[i];
    end
  end

  // All state. The count update on a load edge still uses the old period_r,
  // since the comparison reads the register before it is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= '0;
      period_r <= '1;
      mode_r   <= '0;
      duty_r   <= '0;
      tick_cnt <= '0;
      blink_q  <= '0;
      pwm_cnt  <= '0;
      led_r    <= '0;
    end else begin
      if (en) begin
        count_r <= tick ? '0 : count_r + WIDTH'(1);
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (tick) begin
        tick_cnt <= tick_cnt + CHANNELS'(1);
      end
      blink_q <= blink_next;
      led_r   <= led_next;
      if (load) begin
        period_r <= period;
        mode_r   <= mode;
        duty_r   <= duty;
      end
    end
  end

endmodule
